// File: rtl/instr_encoder_if.sv
// Bundle/memory-write interface for instr_encoder.
//   master : loader side; drives the field bundle, wr_ready and err_clr.
//   slave  : encoder side; drives in_ready, the write request, status and debug state.
// Handshakes: a bundle transfers on a rising edge where in_valid && in_ready;
// a word is written on a rising edge where wr_en && wr_ready. While wr_en is high,
// wr_addr and wr_data stay stable until that edge.
interface instr_encoder_if #(
  parameter int DEPTH = 64
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_sel;
  logic [6:0]    in_opcode;
  logic [4:0]    in_rd;
  logic [2:0]    in_funct3;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [31:0]   in_imm;
  logic          wr_en;
  logic          wr_ready;
  logic [31:0]   wr_addr;
  logic [31:0]   wr_data;
  logic          err;
  logic          err_clr;
  logic          wrapped;
  logic [CW-1:0] count;
  logic [1:0]    dbg_state;  // encoder FSM state, for checkers

  modport master (
    output in_valid, in_sel, in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_imm,
           wr_ready, err_clr,
    input  in_ready, wr_en, wr_addr, wr_data, err, wrapped, count, dbg_state
  );

  modport slave (
    input  in_valid, in_sel, in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_imm,
           wr_ready, err_clr,
    output in_ready, wr_en, wr_addr, wr_data, err, wrapped, count, dbg_state
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded fields and a signed immediate into an RV32I
// instruction word (formats I/S/B/U/J selected by in_sel), range-checks the
// immediate, and writes the word to instruction memory at an auto-incrementing
// byte address BASE_ADDR + 4*index (index wraps modulo DEPTH).
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - instr_encoder_if.slave: field bundle (in_*), memory write (wr_*),
//          sticky err/err_clr, sticky wrapped, saturating count, dbg_state.
// FSM: IDLE -> CHECK -> WRITE -> IDLE; CHECK -> ERR on a violation; ERR -> IDLE on err_clr.
module instr_encoder #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  instr_encoder_if.slave  bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_WRITE = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [2:0]    r_sel;
  logic [6:0]    r_opcode;
  logic [4:0]    r_rd;
  logic [2:0]    r_funct3;
  logic [4:0]    r_rs1;
  logic [4:0]    r_rs2;
  logic [31:0]   r_imm;
  logic [31:0]   r_wr_data;
  logic [IW-1:0] r_index;
  logic [CW-1:0] r_count;
  logic          r_err;
  logic          r_wrapped;

  logic          w_accept;
  logic          w_viol;
  logic [31:0]   w_packed;
  logic signed [31:0] w_simm;

  assign w_accept = (r_state == S_IDLE) && bus.in_valid;
  assign w_simm   = $signed(r_imm);

  // Range / alignment check on the registered bundle.
  always_comb begin
    w_viol = 1'b0;
    case (r_sel)
      3'b000, 3'b001: w_viol = (w_simm < -32'sd2048) || (w_simm > 32'sd2047);
      3'b010:         w_viol = (w_simm < -32'sd4096) || (w_simm > 32'sd4094) || r_imm[0];
      3'b011:         w_viol = (r_imm[11:0] != 12'h000);
      3'b100:         w_viol = (w_simm < -32'sd1048576) || (w_simm > 32'sd1048574) || r_imm[0];
      default:        w_viol = 1'b1;
    endcase
  end

  // Field packing; opcode always occupies [6:0].
  always_comb begin
    w_packed = 32'h0000_0000;
    case (r_sel)
      3'b000: w_packed = {r_imm[11:0], r_rs1, r_funct3, r_rd, r_opcode};
      3'b001: w_packed = {r_imm[11:5], r_rs2, r_rs1, r_funct3, r_imm[4:0], r_opcode};
      3'b010: w_packed = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_funct3,
                          r_imm[4:1], r_imm[11], r_opcode};
      3'b011: w_packed = {r_imm[31:12], r_rd, r_opcode};
      3'b100: w_packed = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, r_opcode};
      default: w_packed = 32'h0000_0000;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_next = S_CHECK;
      S_CHECK: w_next = w_viol ? S_ERR : S_WRITE;
      S_WRITE: if (bus.wr_ready) w_next = S_IDLE;
      S_ERR:   if (bus.err_clr) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Datapath and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel     <= 3'd0;
      r_opcode  <= 7'd0;
      r_rd      <= 5'd0;
      r_funct3  <= 3'd0;
      r_rs1     <= 5'd0;
      r_rs2     <= 5'd0;
      r_imm     <= 32'd0;
      r_wr_data <= 32'd0;
      r_index   <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sel    <= bus.in_sel;
        r_opcode <= bus.in_opcode;
        r_rd     <= bus.in_rd;
        r_funct3 <= bus.in_funct3;
        r_rs1    <= bus.in_rs1;
        r_rs2    <= bus.in_rs2;
        r_imm    <= bus.in_imm;
      end
      if (r_state == S_CHECK) begin
        if (w_viol) r_err     <= 1'b1;
        else        r_wr_data <= w_packed;
      end
      if ((r_state == S_WRITE) && bus.wr_ready) begin
        // Power-of-two DEPTH: the increment wraps naturally.
        r_index <= r_index + IW'(1);
        if (r_index == IW'(DEPTH - 1)) r_wrapped <= 1'b1;
        if (r_count != {CW{1'b1}})     r_count   <= r_count + CW'(1);
      end
      if ((r_state == S_ERR) && bus.err_clr) r_err <= 1'b0;
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.wr_en     = (r_state == S_WRITE);
  assign bus.wr_data   = r_wr_data;
  assign bus.wr_addr   = BASE_ADDR + {{(30 - IW){1'b0}}, r_index, 2'b00};
  assign bus.err       = r_err;
  assign bus.wrapped   = r_wrapped;
  assign bus.count     = r_count;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder (DEPTH=4 so wrap and count saturation are reachable).
module tb_instr_encoder;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam int          CMAX  = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_encoder_if #(.DEPTH(DEPTH)) bus ();

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_imm_q[$];
  logic [2:0]  exp_sel_q[$];

  int m_index;
  int m_count;
  bit m_wrapped;

  // ---------------- reference model ----------------
  function automatic longint unsigned fld(input longint unsigned x, input int hi, input int lo);
    return (x >> lo) & ((64'd1 << (hi - lo + 1)) - 1);
  endfunction

  function automatic bit model_legal(input logic [2:0] sel, input logic [31:0] imm);
    longint v;
    v = longint'($signed(imm));
    case (sel)
      3'd0, 3'd1: return (v >= -2048) && (v <= 2047);
      3'd2:       return (v >= -4096) && (v <= 4094) && (v % 2 == 0);
      3'd3:       return (longint'(imm) % 4096) == 0;
      3'd4:       return (v >= -(64'sd1 << 20)) && (v <= (64'sd1 << 20) - 2) && (v % 2 == 0);
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_encode(input logic [2:0] sel, input logic [6:0] op,
                                               input logic [4:0] rd, input logic [2:0] f3,
                                               input logic [4:0] rs1, input logic [4:0] rs2,
                                               input logic [31:0] imm);
    longint unsigned u, w, vrd, vf3, vrs1, vrs2;
    u = longint'(imm); w = longint'(op);
    vrd = longint'(rd); vf3 = longint'(f3); vrs1 = longint'(rs1); vrs2 = longint'(rs2);
    case (sel)
      3'd0: w = w + (fld(u, 11, 0) << 20) + (vrs1 << 15) + (vf3 << 12) + (vrd << 7);
      3'd1: w = w + (fld(u, 11, 5) << 25) + (vrs2 << 20) + (vrs1 << 15) + (vf3 << 12)
                  + (fld(u, 4, 0) << 7);
      3'd2: w = w + (fld(u, 12, 12) << 31) + (fld(u, 10, 5) << 25) + (vrs2 << 20)
                  + (vrs1 << 15) + (vf3 << 12) + (fld(u, 4, 1) << 8) + (fld(u, 11, 11) << 7);
      3'd3: w = w + (fld(u, 31, 12) << 12) + (vrd << 7);
      3'd4: w = w + (fld(u, 20, 20) << 31) + (fld(u, 10, 1) << 21) + (fld(u, 11, 11) << 20)
                  + (fld(u, 19, 12) << 12) + (vrd << 7);
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  // Sign extender (decoder direction) used for the round-trip check.
  function automatic logic [31:0] model_decode(input logic [31:0] word, input logic [2:0] sel);
    longint unsigned w;
    longint v;
    int n;
    w = longint'(word);
    v = 0; n = 32;
    case (sel)
      3'd0: begin v = longint'(fld(w, 31, 20)); n = 12; end
      3'd1: begin v = longint'((fld(w, 31, 25) << 5) + fld(w, 11, 7)); n = 12; end
      3'd2: begin v = longint'((fld(w, 31, 31) << 12) + (fld(w, 7, 7) << 11)
                             + (fld(w, 30, 25) << 5) + (fld(w, 11, 8) << 1)); n = 13; end
      3'd3: begin v = longint'(fld(w, 31, 12) << 12); n = 32; end
      3'd4: begin v = longint'((fld(w, 31, 31) << 20) + (fld(w, 19, 12) << 12)
                             + (fld(w, 20, 20) << 11) + (fld(w, 30, 21) << 1)); n = 21; end
      default: begin v = 0; n = 32; end
    endcase
    if (v >= (64'sd1 << (n - 1))) v = v - (64'sd1 << n);
    return v[31:0];
  endfunction

  function automatic logic [31:0] gen_imm(input logic [2:0] sel);
    int lo, hi, m, r;
    m = int'($urandom_range(0, 4));
    lo = 0; hi = 0;
    case (sel)
      3'd0, 3'd1: begin lo = -2048;    hi = 2047;        end
      3'd2:       begin lo = -4096;    hi = 4094;        end
      3'd4:       begin lo = -1048576; hi = 1048574;     end
      3'd3: begin
        if (m < 3) return {$urandom_range(0, 32'hFFFFF), 12'h000} ;
        else       return $urandom | 32'h1;
      end
      default: return $urandom;
    endcase
    case (m)
      0: begin
        r = lo + int'($urandom_range(0, hi - lo));
        if (sel != 3'd0 && sel != 3'd1) r = r & ~1;
      end
      1: r = lo;
      2: r = hi;
      3: r = ($urandom_range(0, 1) == 1) ? hi + 2 : lo - 2;
      default: r = (lo + int'($urandom_range(0, hi - lo))) | 1;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] exp_addr();
    return BASE + 32'(4 * m_index);
  endfunction

  // ---------------- write monitor ----------------
  always @(negedge clk) begin
    if (!rst && bus.wr_en === 1'b1 && bus.wr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write", bus.wr_addr, bus.wr_data);
      end else begin
        logic [31:0] d, a, im;
        logic [2:0]  s;
        d = exp_q.pop_front(); a = exp_addr_q.pop_front();
        im = exp_imm_q.pop_front(); s = exp_sel_q.pop_front();
        checks++;
        if (bus.wr_data !== d) begin
          errors++; $display("FAIL write_data: got %h required %h", bus.wr_data, d);
        end
        checks++;
        if (bus.wr_addr !== a) begin
          errors++; $display("FAIL write_addr: got %h required %h", bus.wr_addr, a);
        end
        checks++;
        if (model_decode(bus.wr_data, s) !== im) begin
          errors++; $display("FAIL round_trip: got %h required %h", model_decode(bus.wr_data, s), im);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    for (int i = 0; i < 50; i++) begin
      if (bus.in_ready === 1'b1) return;
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL ready_timeout: got in_ready %b required 1 within 50 cycles", bus.in_ready);
  endtask

  task automatic model_reset();
    m_index = 0; m_count = 0; m_wrapped = 1'b0;
    exp_q.delete(); exp_addr_q.delete(); exp_imm_q.delete(); exp_sel_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready: got %b required 1", tag, bus.in_ready); end
    checks++;
    if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL %s_wr_en: got %b required 0", tag, bus.wr_en); end
    checks++;
    if (bus.wr_data !== 32'h0) begin errors++; $display("FAIL %s_wr_data: got %h required 0", tag, bus.wr_data); end
    checks++;
    if (bus.wr_addr !== BASE) begin errors++; $display("FAIL %s_wr_addr: got %h required %h", tag, bus.wr_addr, BASE); end
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL %s_err: got %b required 0", tag, bus.err); end
    checks++;
    if (bus.wrapped !== 1'b0) begin errors++; $display("FAIL %s_wrapped: got %b required 0", tag, bus.wrapped); end
    checks++;
    if (bus.count !== CW'(0)) begin errors++; $display("FAIL %s_count: got %0d required 0", tag, bus.count); end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check_reset_values("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic clear_err(input bit with_valid);
    bus.err_clr = 1'b1;
    if (with_valid) begin
      bus.in_sel = 3'd0; bus.in_opcode = 7'h13; bus.in_rd = 5'd1; bus.in_funct3 = 3'd0;
      bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0; bus.in_imm = 32'd1; bus.in_valid = 1'b1;
    end
    @(posedge clk); #1;
    bus.err_clr = 1'b0; bus.in_valid = 1'b0;
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL clear_err: got %b required 0", bus.err); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL clear_in_ready: got %b required 1", bus.in_ready); end
    if (with_valid) begin
      @(posedge clk); #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL clear_wins_ready: got %b required 1", bus.in_ready); end
      checks++;
      if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL clear_wins_wr_en: got %b required 0", bus.wr_en); end
    end
  endtask

  // Sends one bundle and follows it through CHECK and WRITE (or ERR).
  task automatic do_txn(input logic [2:0] sel, input logic [6:0] op, input logic [4:0] rd,
                        input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input int stall, input bit clr_with_valid);
    bit legal;
    logic [31:0] ew, ea;
    legal = model_legal(sel, imm);
    ew = model_encode(sel, op, rd, f3, rs1, rs2, imm);
    ea = exp_addr();
    wait_ready();
    bus.in_sel = sel; bus.in_opcode = op; bus.in_rd = rd; bus.in_funct3 = f3;
    bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL check_in_ready: got %b required 0", bus.in_ready); end
    checks++;
    if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL check_wr_en: got %b required 0", bus.wr_en); end
    if (legal) begin
      exp_q.push_back(ew); exp_addr_q.push_back(ea);
      exp_imm_q.push_back(imm); exp_sel_q.push_back(sel);
    end
    @(posedge clk); #1;
    if (legal) begin
      for (int c = 0; c <= stall; c++) begin
        checks++;
        if (bus.wr_en !== 1'b1) begin errors++; $display("FAIL write_wr_en: got %b required 1", bus.wr_en); end
        checks++;
        if (bus.wr_addr !== ea) begin errors++; $display("FAIL hold_addr: got %h required %h", bus.wr_addr, ea); end
        checks++;
        if (bus.wr_data !== ew) begin errors++; $display("FAIL hold_data: got %h required %h", bus.wr_data, ew); end
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL write_in_ready: got %b required 0", bus.in_ready); end
        if (c < stall) begin
          bus.err_clr = (c == 0);  // must be ignored outside ERR
          @(posedge clk); #1;
          bus.err_clr = 1'b0;
        end
      end
      bus.wr_ready = 1'b1;
      @(posedge clk); #1;
      bus.wr_ready = 1'b0;
      m_index = (m_index + 1) % DEPTH;
      if (m_index == 0) m_wrapped = 1'b1;
      if (m_count < CMAX) m_count++;
      checks++;
      if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL done_wr_en: got %b required 0", bus.wr_en); end
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL done_in_ready: got %b required 1", bus.in_ready); end
      checks++;
      if (bus.count !== CW'(m_count)) begin errors++; $display("FAIL done_count: got %0d required %0d", bus.count, m_count); end
      checks++;
      if (bus.wrapped !== m_wrapped) begin errors++; $display("FAIL done_wrapped: got %b required %b", bus.wrapped, m_wrapped); end
      checks++;
      if (bus.err !== 1'b0) begin errors++; $display("FAIL done_err: got %b required 0", bus.err); end
    end else begin
      for (int c = 0; c < 2; c++) begin
        checks++;
        if (bus.err !== 1'b1) begin errors++; $display("FAIL viol_err: sel %0d imm %h got %b required 1", sel, imm, bus.err); end
        checks++;
        if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL viol_wr_en: got %b required 0", bus.wr_en); end
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL viol_in_ready: got %b required 0", bus.in_ready); end
        checks++;
        if (bus.count !== CW'(m_count)) begin errors++; $display("FAIL viol_count: got %0d required %0d", bus.count, m_count); end
        if (c == 0) begin @(posedge clk); #1; end
      end
      clear_err(clr_with_valid);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_sel = 3'd0; bus.in_opcode = 7'd0; bus.in_rd = 5'd0;
    bus.in_funct3 = 3'd0; bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0; bus.in_imm = 32'd0;
    bus.wr_ready = 1'b0; bus.err_clr = 1'b0;
    apply_reset();
    check_reset_values("after_reset");
  endtask

  task automatic test_directed();
    do_txn(3'd0, 7'h13, 5'd3, 3'd0, 5'd0, 5'd0, 32'hFFFF_FFFB, 0, 1'b0);
    checks++;
    if (bus.wr_data !== 32'hFFB0_0193) begin errors++; $display("FAIL t1_word: got %h required FFB00193", bus.wr_data); end
    do_txn(3'd2, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 32'hFFFF_FFF8, 0, 1'b0);
    checks++;
    if (bus.wr_data !== 32'hFE00_0CE3) begin errors++; $display("FAIL t2_b_word: got %h required FE000CE3", bus.wr_data); end
    do_txn(3'd3, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 32'h1234_5000, 0, 1'b0);
    checks++;
    if (bus.wr_data !== 32'h1234_52B7) begin errors++; $display("FAIL t2_u_word: got %h required 123452B7", bus.wr_data); end
    do_txn(3'd1, 7'h23, 5'd0, 3'd2, 5'd7, 5'd9, 32'h0000_07FF, 0, 1'b0);
  endtask

  task automatic test_errors();
    do_txn(3'd0, 7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 32'd2048, 0, 1'b0);
    do_txn(3'd4, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'd3, 0, 1'b0);
    do_txn(3'd6, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd0, 0, 1'b1);
    do_txn(3'd3, 7'h37, 5'd1, 3'd0, 5'd0, 5'd0, 32'h0000_1001, 0, 1'b0);
  endtask

  task automatic test_stall();
    do_txn(3'd4, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'hFFF0_0000, 5, 1'b0);
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 5; i++)
      do_txn(3'd0, 7'h13, 5'(i + 1), 3'd0, 5'd0, 5'd0, 32'(i * 10), 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [2:0] s;
      s = 3'($urandom_range(0, 7));
      do_txn(s, 7'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
             gen_imm(s), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_write();
    wait_ready();
    bus.in_sel = 3'd0; bus.in_opcode = 7'h13; bus.in_rd = 5'd4; bus.in_funct3 = 3'd0;
    bus.in_rs1 = 5'd1; bus.in_rs2 = 5'd0; bus.in_imm = 32'd100; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.wr_en !== 1'b1) begin errors++; $display("FAIL mid_write_wr_en: got %b required 1", bus.wr_en); end
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_values("mid_write");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_txn(3'd0, 7'h13, 5'd4, 3'd0, 5'd1, 5'd0, 32'd100, 0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_stall();
    test_wrap();
    test_random();
    test_reset_mid_write();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL pending_writes: got %0d required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
